// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Purpose  : ID-stage branch resolution controller. Detects data hazards on
//            the comparer operands, inserts stall cycles, selects EX/MEM
//            forwarding for the comparer, and issues a one-cycle registered
//            PC redirect with IF/ID flush for taken beq/bne.
// Options  : BRANCH_CTRL_STATS_EN adds saturating taken/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
  parameter int BUS_SIZE = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_beq,
  input  logic                id_bne,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [BUS_SIZE-1:0] id_target,
  input  logic                cmp_eq,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic [4:0]          ex_rd,
  input  logic                mem_regwrite,
  input  logic                mem_memread,
  input  logic [4:0]          mem_rd,
  output logic                stall,
  output logic                flush_if,
  output logic                pc_src,
  output logic [BUS_SIZE-1:0] pc_target,
  output logic                fwd_a,
  output logic                fwd_b
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0]         taken_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT2   = 2'd1,
    WAIT1   = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  pc_src_q, pc_src_d;
  logic                  flush_q, flush_d;
  logic [BUS_SIZE-1:0]   target_q, target_d;

  logic is_branch;
  logic taken;
  logic resolve;
  logic redirect;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic ex_load_hit, one_cycle_hit;

  // Register 0 is hard-wired, so it can never be a hazard source.
  assign ex_hit_a  = ex_regwrite  && (ex_rd  == id_rs) && (id_rs != 5'd0);
  assign ex_hit_b  = ex_regwrite  && (ex_rd  == id_rt) && (id_rt != 5'd0);
  assign mem_hit_a = mem_regwrite && (mem_rd == id_rs) && (id_rs != 5'd0);
  assign mem_hit_b = mem_regwrite && (mem_rd == id_rt) && (id_rt != 5'd0);

  // A load in EX needs two extra cycles; an ALU op in EX or a load in MEM
  // needs one. An ALU result already in MEM is forwarded instead.
  assign ex_load_hit   = (ex_hit_a || ex_hit_b) && ex_memread;
  assign one_cycle_hit = ((ex_hit_a || ex_hit_b) && !ex_memread) ||
                         ((mem_hit_a || mem_hit_b) && mem_memread);

  assign fwd_a = mem_hit_a && !mem_memread;
  assign fwd_b = mem_hit_b && !mem_memread;

  assign is_branch = id_beq || id_bne;
  assign taken     = (id_beq && cmp_eq) || (id_bne && !cmp_eq);
  assign redirect  = resolve && taken;

  // Stall is decoded straight from the state register so it is glitch-free
  // and drops immediately when reset is asserted.
  assign stall = (state_q == WAIT2) || (state_q == WAIT1);

  assign pc_src    = pc_src_q;
  assign flush_if  = flush_q;
  assign pc_target = target_q;

  // Next-state and resolve decision.
  always_comb begin
    state_d = state_q;
    resolve = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_branch) begin
          if (ex_load_hit) begin
            state_d = WAIT2;
          end else if (one_cycle_hit) begin
            state_d = WAIT1;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      WAIT2:   state_d = is_branch ? WAIT1 : IDLE;
      WAIT1:   state_d = is_branch ? RESOLVE : IDLE;
      RESOLVE: begin
        state_d = IDLE;
        resolve = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect outputs: pulse for one cycle after a taken resolve.
  always_comb begin
    pc_src_d = redirect;
    flush_d  = redirect;
    target_d = redirect ? id_target : target_q;
  end

  // State and redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_src_q <= 1'b0;
      flush_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_src_q <= pc_src_d;
      flush_q  <= flush_d;
      target_q <= target_d;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating counter increments.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (redirect && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Purpose  : Directed self-checking bench for branch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

  localparam int BUS_SIZE = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_beq, id_bne;
  logic [4:0]          id_rs, id_rt;
  logic [BUS_SIZE-1:0] id_target;
  logic                cmp_eq;
  logic                ex_regwrite, ex_memread;
  logic [4:0]          ex_rd;
  logic                mem_regwrite, mem_memread;
  logic [4:0]          mem_rd;
  logic                stall, flush_if, pc_src;
  logic [BUS_SIZE-1:0] pc_target;
  logic                fwd_a, fwd_b;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0]         taken_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  branch_ctrl #(.BUS_SIZE(BUS_SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_beq       (id_beq),
    .id_bne       (id_bne),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_target    (id_target),
    .cmp_eq       (cmp_eq),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .stall        (stall),
    .flush_if     (flush_if),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_beq = 0; id_bne = 0; id_rs = 0; id_rt = 0; id_target = '0; cmp_eq = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
  endtask

  // stall and flush_if must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(stall === 1'b1 && flush_if === 1'b1)) else begin
        failures++;
        $error("FAIL stall_flush_excl observed=%0b%0b expected=not_both", stall, flush_if);
      end
    end
  end

  initial begin
    clear_in();
    rst_n = 0;
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_flush", flush_if, 0);
    chk("rst_target", pc_target, 0);
    rst_n = 1;
    tick();

    // beq r3,r4 taken, no hazards: redirect on the next edge, no stall.
    id_beq = 1; id_rs = 3; id_rt = 4; cmp_eq = 1; id_target = 10'h040;
    #1;
    chk("beq_nohaz_stall", stall, 0);
    chk("beq_nohaz_fwd_a", fwd_a, 0);
    tick();
    chk("beq_nohaz_pc_src", pc_src, 1);
    chk("beq_nohaz_flush", flush_if, 1);
    chk("beq_nohaz_target", pc_target, 10'h040);
    chk("beq_nohaz_stall2", stall, 0);
    clear_in();
    tick();
    chk("beq_nohaz_pulse_end", pc_src, 0);
    chk("beq_nohaz_flush_end", flush_if, 0);

    // bne r5,r6 behind a load into r5: two stall cycles then taken.
    id_bne = 1; id_rs = 5; id_rt = 6; cmp_eq = 0; id_target = 10'h123;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    tick();
    chk("ld_stall_c1", stall, 1);
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    tick();
    chk("ld_stall_c2", stall, 1);
    chk("ld_no_early_redirect", pc_src, 0);
    tick();
    chk("ld_resolve_stall", stall, 0);
    chk("ld_resolve_pc_src", pc_src, 0);
    tick();
    chk("ld_pc_src", pc_src, 1);
    chk("ld_flush", flush_if, 1);
    chk("ld_target", pc_target, 10'h123);
    chk("ld_post_stall", stall, 0);
    clear_in();
    tick();
    chk("ld_pulse_end", pc_src, 0);

    // beq r2,r0 behind an ALU write of r2: one stall, not taken.
    id_beq = 1; id_rs = 2; id_rt = 0; cmp_eq = 0; id_target = 10'h0AA;
    ex_regwrite = 1; ex_memread = 0; ex_rd = 2;
    tick();
    chk("alu_stall_c1", stall, 1);
    ex_regwrite = 0; ex_rd = 0;
    tick();
    chk("alu_resolve_stall", stall, 0);
    tick();
    chk("alu_not_taken_pc_src", pc_src, 0);
    chk("alu_not_taken_flush", flush_if, 0);
    chk("alu_target_held", pc_target, 10'h123);
    clear_in();

    // beq r0,r1 with ex_rd=0: register 0 never matches, so no stall.
    id_beq = 1; id_rs = 0; id_rt = 1; cmp_eq = 1; id_target = 10'h2AA;
    ex_regwrite = 1; ex_rd = 0;
    #1;
    chk("r0_no_stall", stall, 0);
    tick();
    chk("r0_stall_after", stall, 0);
    chk("r0_pc_src", pc_src, 1);
    chk("r0_target", pc_target, 10'h2AA);
    clear_in();
    tick();

    // beq r7,r8 with ALU result for r8 in MEM: forward b, no stall.
    id_beq = 1; id_rs = 7; id_rt = 8; cmp_eq = 0;
    mem_regwrite = 1; mem_memread = 0; mem_rd = 8;
    #1;
    chk("mem_fwd_b", fwd_b, 1);
    chk("mem_fwd_a", fwd_a, 0);
    id_rs = 8;
    #1;
    chk("mem_fwd_a_both", fwd_a, 1);
    id_rs = 7;
    tick();
    chk("mem_fwd_no_stall", stall, 0);
    chk("mem_fwd_not_taken", pc_src, 0);
    clear_in();

    // Load in MEM feeding rt: one stall, no forward.
    id_beq = 1; id_rs = 7; id_rt = 9; cmp_eq = 1; id_target = 10'h311;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 9;
    #1;
    chk("memld_no_fwd", fwd_b, 0);
    tick();
    chk("memld_stall", stall, 1);
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    tick();
    chk("memld_resolve", stall, 0);
    tick();
    chk("memld_pc_src", pc_src, 1);
    chk("memld_target", pc_target, 10'h311);
    clear_in();
    tick();

    // Branch dropped while waiting: back to IDLE, no redirect.
    id_bne = 1; id_rs = 4; id_rt = 3; cmp_eq = 0; id_target = 10'h155;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    tick();
    chk("drop_stall", stall, 1);
    clear_in();
    tick();
    chk("drop_idle", stall, 0);
    tick();
    chk("drop_no_redirect", pc_src, 0);
    chk("drop_target_held", pc_target, 10'h311);

    // Reset asserted in WAIT2: outputs clear at once, no redirect later.
    id_beq = 1; id_rs = 6; id_rt = 2; cmp_eq = 1; id_target = 10'h3C0;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 6;
    tick();
    chk("wait2_stall", stall, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_pc_src", pc_src, 0);
    chk("async_rst_target", pc_target, 0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("async_rst_taken_cnt", taken_cnt, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
`endif
    clear_in();
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_pc_src", pc_src, 0);
      chk("post_rst_no_stall", stall, 0);
    end

`ifdef BRANCH_CTRL_STATS_EN
    // Three taken branches, one behind a load: 3 taken, 2 stall cycles.
    id_beq = 1; id_rs = 3; id_rt = 4; cmp_eq = 1; id_target = 10'h010;
    tick();
    clear_in();
    id_bne = 1; id_rs = 5; id_rt = 6; cmp_eq = 0; id_target = 10'h020;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    tick();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    tick();
    tick();
    tick();
    clear_in();
    id_beq = 1; id_rs = 1; id_rt = 2; cmp_eq = 1; id_target = 10'h030;
    tick();
    clear_in();
    tick();
    chk("stats_taken_cnt", taken_cnt, 3);
    chk("stats_stall_cnt", stall_cnt, 2);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: BUS_SIZE, default 10, width of branch target and compared operands.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: id_beq, id_bne  input  1 each  ID holds beq / bne (mutually exclusive).
REQ-005 Port: id_rs, id_rt  input  5 each  source register numbers feeding the ID comparer.
REQ-006 Port: id_target  input  BUS_SIZE  computed branch target address.
REQ-007 Port: cmp_eq  input  1  equality result from ID comparer (post-forwarding operands).
REQ-008 Port: ex_regwrite, ex_memread  input  1 each; ex_rd  input  5  EX-stage destination info.
REQ-009 Port: mem_regwrite, mem_memread  input  1 each; mem_rd  input  5  MEM-stage destination info.
REQ-010 Port: stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-011 Port: flush_if  output  1  squash IF/ID contents next edge.
REQ-012 Port: pc_src  output  1  select pc_target for next PC.
REQ-013 Port: pc_target  output  BUS_SIZE  registered redirect address.
REQ-014 Port: fwd_a, fwd_b  output  1 each  select EX/MEM ALU result for comparer operand a / b.

Function
REQ-015 Hazard match: stage X matches operand r when X_regwrite=1, X_rd==r, r!=0; register 0 never matches.
REQ-016 States: IDLE, WAIT2, WAIT1, RESOLVE; 2-bit state register.
REQ-017 IDLE, no branch (id_beq=id_bne=0): stay IDLE, stall=0, pc_src=0, flush_if=0.
REQ-018 IDLE, branch, EX match with ex_memread=1 -> WAIT2; stall=1.
REQ-019 IDLE, branch, EX match with ex_memread=0, or MEM match with mem_memread=1 -> WAIT1; stall=1.
REQ-020 IDLE, branch, no stalling match -> RESOLVE decision this cycle (zero added latency).
REQ-021 WAIT2 -> WAIT1 unconditionally, stall=1; WAIT1 -> RESOLVE, stall=1; hazard inputs ignored while waiting.
REQ-022 Resolve: taken = (id_beq & cmp_eq) | (id_bne & ~cmp_eq); on taken, next edge sets pc_src=1, flush_if=1, pc_target=id_target for exactly one cycle; not taken: both 0.
REQ-023 Resolve cycle returns to IDLE; stall=0 in resolve cycle.
REQ-024 fwd_a=1 when MEM match on id_rs with mem_memread=0; fwd_b likewise for id_rt; combinational, valid in every state.
REQ-025 Branch dropped (id_beq=id_bne=0) while in WAIT2/WAIT1 -> IDLE next edge, no redirect.
REQ-026 stall and flush_if never both 1 in the same cycle.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, stall=0, flush_if=0, pc_src=0, pc_target=0, counters 0.
REQ-028 Reset asserted mid-stall abandons the pending branch; no redirect after release.

Configuration
REQ-029 Macro BRANCH_CTRL_STATS_EN defined: adds outputs taken_cnt (16) and stall_cnt (16); taken_cnt +1 per taken resolve, stall_cnt +1 per cycle stall=1; both saturate at 16'hFFFF.
REQ-030 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-031 beq r3,r4; no hazards; cmp_eq=1; id_target=10'h040 -> next cycle pc_src=1, flush_if=1, pc_target=10'h040; stall never 1.
REQ-032 bne r5,r6; ex_memread=1, ex_rd=5 -> stall=1 for 2 cycles, then cmp_eq=0 resolves taken.
REQ-033 beq r2,r0; ex_regwrite=1, ex_rd=2, ex_memread=0 -> stall=1 for 1 cycle; beq r0,r1 with ex_rd=0 -> no stall.
REQ-034 beq r7,r8; mem_regwrite=1, mem_rd=8, mem_memread=0 -> fwd_b=1, fwd_a=0, no stall.
REQ-035 rst_n low in WAIT2 -> outputs 0 immediately, no pc_src pulse after release.
REQ-036 With BRANCH_CTRL_STATS_EN: three taken branches, one with 2-cycle load stall -> taken_cnt=3, stall_cnt=2.
